// File: rtl/fft_pkg.sv
// Shared FFT datapath types and constants.
// Q8.8 complex sample and saturation helper.
package fft_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int N_FFT   = 16;
  localparam int TW_NUM  = 8;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  localparam int IDX_W  = $clog2(N_FFT);
  localparam int TW_W   = $clog2(TW_NUM);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 1;

  typedef logic signed [DATA_W-1:0] q88_t;

  typedef struct packed {
    q88_t re;
    q88_t im;
  } cplx_t;

  function automatic q88_t sat(
    input logic signed [SUM_W-1:0] x
  );
    if (x > SUM_W'(SAT_MAX)) begin
      sat = q88_t'(SAT_MAX);
    end else if (x < SUM_W'(SAT_MIN)) begin
      sat = q88_t'(SAT_MIN);
    end else begin
      sat = x[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/twiddle_mult_if.sv
// Sample stream handshake bundle for the
// twiddle-multiply stage.
interface twiddle_mult_if;
  import fft_pkg::*;

  logic in_valid;
  logic in_ready;
  q88_t in_r;
  q88_t in_i;
  logic out_valid;
  logic out_ready;
  q88_t out_r;
  q88_t out_i;
  logic out_last;

  modport master (
    output in_valid,
    output in_r,
    output in_i,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_r,
    input  out_i,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_r,
    input  in_i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_r,
    output out_i,
    output out_last
  );

endinterface

// File: rtl/cmul_q88.sv
// Two-stage Q8.8 complex multiplier with bypass.
// TWMUL_ROUND_EN: round half up before the shift.
module cmul_q88
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  byp,
  input  cplx_t a,
  input  cplx_t w,
  output cplx_t y
);

`ifdef TWMUL_ROUND_EN
  localparam int RND = 2 ** (FRAC_W - 1);
`else
  localparam int RND = 0;
`endif

  logic signed [PROD_W-1:0] rr_d, rr_q;
  logic signed [PROD_W-1:0] ii_d, ii_q;
  logic signed [PROD_W-1:0] ri_d, ri_q;
  logic signed [PROD_W-1:0] ir_d, ir_q;
  logic  byp_d, byp_q;
  cplx_t a_d, a_q;
  cplx_t y_d, y_q;

  logic signed [SUM_W-1:0] re_s, im_s;
  logic signed [SUM_W-1:0] re_t, im_t;

  always_comb begin
    rr_d  = rr_q;
    ii_d  = ii_q;
    ri_d  = ri_q;
    ir_d  = ir_q;
    byp_d = byp_q;
    a_d   = a_q;
    if (en) begin
      rr_d  = PROD_W'($signed(a.re))
            * PROD_W'($signed(w.re));
      ii_d  = PROD_W'($signed(a.im))
            * PROD_W'($signed(w.im));
      ri_d  = PROD_W'($signed(a.re))
            * PROD_W'($signed(w.im));
      ir_d  = PROD_W'($signed(a.im))
            * PROD_W'($signed(w.re));
      byp_d = byp;
      a_d   = a;
    end
  end

  always_comb begin
    re_s = SUM_W'(rr_q) - SUM_W'(ii_q)
         + SUM_W'(RND);
    im_s = SUM_W'(ri_q) + SUM_W'(ir_q)
         + SUM_W'(RND);
    re_t = re_s >>> FRAC_W;
    im_t = im_s >>> FRAC_W;
    y_d  = y_q;
    if (en) begin
      // Bypass forwards the raw input so it
      // never sees rounding or saturation.
      if (byp_q) begin
        y_d = a_q;
      end else begin
        y_d.re = sat(re_t);
        y_d.im = sat(im_t);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= '0;
      ii_q  <= '0;
      ri_q  <= '0;
      ir_q  <= '0;
      byp_q <= 1'b0;
      a_q   <= '0;
      y_q   <= '0;
    end else begin
      rr_q  <= rr_d;
      ii_q  <= ii_d;
      ri_q  <= ri_d;
      ir_q  <= ir_d;
      byp_q <= byp_d;
      a_q   <= a_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/twiddle_mult.sv
// FFT twiddle-multiply stage: index counter,
// bypass select, handshake. See TWMUL_ROUND_EN.
module twiddle_mult
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TW_NUM*DATA_W-1:0] tw_r,
  input  logic [TW_NUM*DATA_W-1:0] tw_i,
  twiddle_mult_if.slave            io
);

  logic en;
  logic accept;
  logic byp;
  logic [TW_W-1:0] k;
  cplx_t a, w, y;

  logic [IDX_W-1:0] idx_d, idx_q;
  logic s1_valid_d, s1_valid_q;
  logic s1_last_d, s1_last_q;
  logic out_valid_d, out_valid_q;
  logic out_last_d, out_last_q;

  always_comb begin
    en     = !out_valid_q || io.out_ready;
    accept = io.in_valid && en;
    k      = idx_q[TW_W-1:0];
    byp    = idx_q < IDX_W'(N_FFT / 2);
    a.re   = io.in_r;
    a.im   = io.in_i;
    w.re   = tw_r[DATA_W*int'(k) +: DATA_W];
    w.im   = tw_i[DATA_W*int'(k) +: DATA_W];
  end

  always_comb begin
    idx_d       = idx_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (en) begin
      s1_valid_d  = accept;
      s1_last_d   = accept
                 && (idx_q == IDX_W'(N_FFT - 1));
      out_valid_d = s1_valid_q;
      out_last_d  = s1_last_q;
      if (accept) begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  cmul_q88 u_cmul (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .byp (byp),
    .a   (a),
    .w   (w),
    .y   (y)
  );

  assign io.in_ready  = en;
  assign io.out_valid = out_valid_q;
  assign io.out_r     = y.re;
  assign io.out_i     = y.im;
  assign io.out_last  = out_last_q;

endmodule

// File: tb/tb_twiddle_mult.sv
// Directed bench for twiddle_mult: frames, vectors,
// gaps, backpressure and mid-frame reset.
module tb_twiddle_mult;

  localparam int TWR [8] =
    '{256, 236, 180, 98, 0, -98, -180, -236};
  localparam int TWI [8] =
    '{0, -98, -180, -236, -256, -236, -180, -98};

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] tw_r;
  logic [127:0] tw_i;

  twiddle_mult_if io ();

  twiddle_mult dut (
    .clk  (clk),
    .rst  (rst),
    .tw_r (tw_r),
    .tw_i (tw_i),
    .io   (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit abort = 1'b0;

  logic signed [15:0] st_r [16];
  logic signed [15:0] st_i [16];
  logic signed [15:0] ex_r [16];
  logic signed [15:0] ex_i [16];

  logic signed [15:0] q_r [$];
  logic signed [15:0] q_i [$];
  logic               q_last [$];
  int                 q_cyc [$];
  int                 acc_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (io.out_valid && io.out_ready) begin
        q_r.push_back(io.out_r);
        q_i.push_back(io.out_i);
        q_last.push_back(io.out_last);
        q_cyc.push_back(cyc);
      end
      if (io.in_valid && io.in_ready)
        acc_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_r.delete();
    q_i.delete();
    q_last.delete();
    q_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input int n, input bit gaps);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 2000 && !abort) begin
      @(posedge clk);
      #1;
      if (gaps && $urandom_range(0, 2) == 0) begin
        io.in_valid = 1'b0;
      end else begin
        io.in_valid = 1'b1;
        io.in_r = st_r[sent];
        io.in_i = st_i[sent];
      end
      @(negedge clk);
      if (io.in_valid && io.in_ready) sent++;
      guard++;
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    if (!abort) begin
      checks++;
      if (sent != n) begin
        errors++;
        $display("FAIL send_timeout got %0d want %0d",
                 sent, n);
      end
    end
  endtask

  task automatic wait_out(input int n, output bit ok);
    int g = 0;
    while (q_r.size() < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (6) @(negedge clk);
    ok = (q_r.size() == n);
  endtask

  task automatic load_unit();
    for (int i = 0; i < 16; i++) begin
      st_r[i] = 16'sd256;
      st_i[i] = 16'sd0;
      ex_r[i] = (i < 8) ? 16'sd256 : 16'(TWR[i-8]);
      ex_i[i] = (i < 8) ? 16'sd0 : 16'(TWI[i-8]);
    end
  endtask

  task automatic load_vec();
    for (int i = 0; i < 16; i++) begin
      st_r[i] = '0;
      st_i[i] = '0;
      ex_r[i] = '0;
      ex_i[i] = '0;
    end
    st_r[3] = -16'sd32768; st_i[3] = 16'sd32767;
    ex_r[3] = -16'sd32768; ex_i[3] = 16'sd32767;
    st_r[5] = 16'sd1234;   st_i[5] = -16'sd77;
    ex_r[5] = 16'sd1234;   ex_i[5] = -16'sd77;
    st_r[8] = 16'sd100;    st_i[8] = -16'sd50;
    ex_r[8] = 16'sd100;    ex_i[8] = -16'sd50;
    st_r[9] = 16'sd1;      st_i[9] = 16'sd0;
`ifdef TWMUL_ROUND_EN
    ex_r[9] = 16'sd1;      ex_i[9] = 16'sd0;
`else
    ex_r[9] = 16'sd0;      ex_i[9] = -16'sd1;
`endif
    st_r[10] = 16'sd32767; st_i[10] = 16'sd32767;
    ex_r[10] = 16'sd32767; ex_i[10] = 16'sd0;
    st_r[11] = 16'sd256;   st_i[11] = 16'sd0;
    ex_r[11] = 16'sd98;    ex_i[11] = -16'sd236;
    st_r[12] = 16'sd256;   st_i[12] = 16'sd256;
    ex_r[12] = 16'sd256;   ex_i[12] = -16'sd256;
    st_r[13] = 16'sd0;     st_i[13] = 16'sd256;
    ex_r[13] = 16'sd236;   ex_i[13] = -16'sd98;
    st_r[14] = 16'sd32767; st_i[14] = 16'sd32767;
    ex_r[14] = 16'sd0;     ex_i[14] = -16'sd32768;
    st_r[15] = -16'sd256;  st_i[15] = 16'sd512;
    ex_r[15] = 16'sd432;   ex_i[15] = -16'sd374;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    io.in_valid = 1'b0;
    io.in_r = '0;
    io.in_i = '0;
    io.out_ready = 1'b1;
    #12;
    checks++;
    if (io.out_valid !== 1'b0 || io.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b l=%b want 0 0",
               io.out_valid, io.out_last);
    end
    checks++;
    if (io.out_r !== 16'sd0 || io.out_i !== 16'sd0) begin
      errors++;
      $display("FAIL reset_data got (%0d,%0d) want (0,0)",
               io.out_r, io.out_i);
    end
    checks++;
    if (io.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1",
               io.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame();
    bit ok;
    int bad;
    clear_q();
    load_unit();
    send(16, 1'b0);
    wait_out(16, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_count got %0d want 16", q_r.size());
    end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_r[i] !== ex_r[i] || q_i[i] !== ex_i[i]) begin
          errors++;
          $display("FAIL frame_s%0d got (%0d,%0d) want (%0d,%0d)",
                   i, q_r[i], q_i[i], ex_r[i], ex_i[i]);
        end
      end
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (q_last[i] !== (i == 15)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL frame_last got %0d bad want 0", bad);
      end
      checks++;
      if (q_cyc[0] - acc_cyc[0] != 2) begin
        errors++;
        $display("FAIL frame_latency got %0d want 2",
                 q_cyc[0] - acc_cyc[0]);
      end
      checks++;
      if (q_cyc[15] - q_cyc[0] != 15) begin
        errors++;
        $display("FAIL frame_rate got %0d want 15",
                 q_cyc[15] - q_cyc[0]);
      end
    end
  endtask

  task automatic test_vectors(input bit gaps);
    bit ok;
    clear_q();
    load_vec();
    send(16, gaps);
    wait_out(16, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL vec_count g=%0d got %0d want 16",
               gaps, q_r.size());
    end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_r[i] !== ex_r[i] || q_i[i] !== ex_i[i]) begin
          errors++;
          $display("FAIL vec_g%0d_s%0d got (%0d,%0d) want (%0d,%0d)",
                   gaps, i, q_r[i], q_i[i], ex_r[i], ex_i[i]);
        end
      end
      checks++;
      if (q_last[15] !== 1'b1 || q_last[14] !== 1'b0) begin
        errors++;
        $display("FAIL vec_last got %b%b want 10",
                 q_last[15], q_last[14]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_q();
    load_unit();
    for (int i = 0; i < 8; i++) begin
      st_r[i] = 16'(i * 100);
      st_i[i] = 16'(-i * 100);
      ex_r[i] = st_r[i];
      ex_i[i] = st_i[i];
    end
    fork
      send(16, 1'b0);
      begin
        int g = 0;
        logic signed [15:0] sr, si;
        logic sl, sv;
        int sa;
        while (acc_cyc.size() < 6 && g < 200) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        @(negedge clk);
        sr = io.out_r;
        si = io.out_i;
        sl = io.out_last;
        sv = io.out_valid;
        sa = acc_cyc.size();
        checks++;
        if (sv !== 1'b1) begin
          errors++;
          $display("FAIL stall_valid got %b want 1", sv);
        end
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (io.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready got %b want 0",
                     io.in_ready);
          end
          checks++;
          if (io.out_r !== sr || io.out_i !== si
              || io.out_last !== sl
              || io.out_valid !== sv
              || acc_cyc.size() != sa) begin
            errors++;
            $display("FAIL stall_hold got (%0d,%0d) n=%0d want (%0d,%0d) n=%0d",
                     io.out_r, io.out_i, acc_cyc.size(),
                     sr, si, sa);
          end
        end
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
      end
    join
    wait_out(16, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_count got %0d want 16", q_r.size());
    end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_r[i] !== ex_r[i] || q_i[i] !== ex_i[i]) begin
          errors++;
          $display("FAIL bp_s%0d got (%0d,%0d) want (%0d,%0d)",
                   i, q_r[i], q_i[i], ex_r[i], ex_i[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int bad;
    clear_q();
    load_unit();
    abort = 1'b0;
    fork
      send(16, 1'b0);
      begin
        int g = 0;
        while (acc_cyc.size() < 6 && g < 200) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (io.out_valid !== 1'b0 || io.out_last !== 1'b0) begin
          errors++;
          $display("FAIL midrst_flush got v=%b l=%b want 0 0",
                   io.out_valid, io.out_last);
        end
        abort = 1'b1;
      end
    join
    abort = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    clear_q();
    send(16, 1'b0);
    wait_out(16, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_count got %0d want 16", q_r.size());
    end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_r[i] !== ex_r[i] || q_i[i] !== ex_i[i]) begin
          errors++;
          $display("FAIL midrst_s%0d got (%0d,%0d) want (%0d,%0d)",
                   i, q_r[i], q_i[i], ex_r[i], ex_i[i]);
        end
      end
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (q_last[i] !== (i == 15)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL midrst_last got %0d bad want 0", bad);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      tw_r[k*16 +: 16] = 16'(TWR[k]);
      tw_i[k*16 +: 16] = 16'(TWI[k]);
    end
    test_reset();
    test_frame();
    test_vectors(1'b0);
    test_vectors(1'b1);
    test_backpressure();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
